alu_issue_ctrl: RTL and testbench

- Issue/sequencing stage directly upstream of the combinational ALU.
- Accepts ALU commands (op, two operands, tag) over a valid/ready handshake and buffers them in a small in-order FIFO.
- Drives the ALU inputs from registers, captures `alu_out`/`alu_overflow` into an output register, and presents results downstream with a valid/ready handshake.

---
 rtl/alu_issue_ctrl_if.sv | 32 +++
 rtl/alu_issue_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: command and result handshakes of the ALU issue stage.
// The slave modport is the issue controller; the master modport is the
// producer of commands and consumer of results.
interface alu_issue_ctrl_if #(
  parameter int TAG_W = 4
);
  // command channel
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_op;
  logic [31:0]      in_src1;
  logic [31:0]      in_src2;
  logic [TAG_W-1:0] in_tag;

  // result channel
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             out_overflow;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport slave (
    input  in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_overflow, out_tag, out_err
  );

  modport master (
    output in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_overflow, out_tag, out_err
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: in-order issue stage in front of a combinational ALU.
// Commands are queued in a DEPTH-entry FIFO, presented to the ALU for one
// cycle from registers, and the ALU result is captured and held until the
// consumer takes it.
// Build option ALU_ILLEGAL_OP_CHK_EN: opcodes above 5'b10001 are sequenced
// with normal timing but never enable the ALU; their result is forced to
// zero with out_err set. Without it, out_err is tied low.
module alu_issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_issue_ctrl_if.slave        bus,
  output logic                   alu_enable,
  output logic [4:0]             alu_op,
  output logic [31:0]            src1,
  output logic [31:0]            src2,
  input  logic [31:0]            alu_out,
  input  logic                   alu_overflow,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int               PTR_W         = $clog2(DEPTH);
  localparam int               CNT_W         = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT      = CNT_W'(DEPTH);
  localparam logic [4:0]       OP_LAST_LEGAL = 5'b10001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // FIFO storage and bookkeeping
  logic [4:0]       r_mem_op   [DEPTH];
  logic [31:0]      r_mem_src1 [DEPTH];
  logic [31:0]      r_mem_src2 [DEPTH];
  logic [TAG_W-1:0] r_mem_tag  [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_in_ready;
  logic w_push;
  logic w_pop;
  logic w_empty;
  logic w_capture;
  logic w_release;

  // issue registers feeding the ALU
  logic [4:0]       r_alu_op;
  logic [31:0]      r_src1;
  logic [31:0]      r_src2;
  logic [TAG_W-1:0] r_issue_tag;
  logic             w_issue_ill;

  // held result
  logic             r_out_valid;
  logic [31:0]      r_out_data;
  logic             r_out_overflow;
  logic [TAG_W-1:0] r_out_tag;
  logic [31:0]      w_cap_data;
  logic             w_cap_ovf;

  // Full is decided on the registered count only, so a pop in the same
  // cycle never opens the input combinationally.
  assign w_in_ready = (r_count != FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign w_push     = bus.in_valid & w_in_ready;

  // Store accepted commands; payload needs no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_op[r_wr_ptr]   <= bus.in_op;
      r_mem_src1[r_wr_ptr] <= bus.in_src1;
      r_mem_src2[r_wr_ptr] <= bus.in_src2;
      r_mem_tag[r_wr_ptr]  <= bus.in_tag;
    end
  end

  // FIFO pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // Occupancy: a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Sequencer decisions: when to pop, capture and release a result.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_capture   = 1'b1;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          w_release = 1'b1;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_ISSUE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Load the FIFO head into the ALU-facing registers on every pop; they
  // keep their last issued values otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_op    <= '0;
      r_src1      <= '0;
      r_src2      <= '0;
      r_issue_tag <= '0;
    end else if (w_pop) begin
      r_alu_op    <= r_mem_op[r_rd_ptr];
      r_src1      <= r_mem_src1[r_rd_ptr];
      r_src2      <= r_mem_src2[r_rd_ptr];
      r_issue_tag <= r_mem_tag[r_rd_ptr];
    end
  end

`ifdef ALU_ILLEGAL_OP_CHK_EN
  logic r_issue_ill;
  logic r_out_err;

  // Classify the opcode as it is popped so the ISSUE cycle can suppress the ALU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_issue_ill <= 1'b0;
    else if (w_pop) r_issue_ill <= (r_mem_op[r_rd_ptr] > OP_LAST_LEGAL);
  end

  // Error flag travels with the captured result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_out_err <= 1'b0;
    else if (w_capture) r_out_err <= r_issue_ill;
  end

  assign w_issue_ill = r_issue_ill;
  assign bus.out_err = r_out_err;
`else
  assign w_issue_ill = 1'b0;
  assign bus.out_err = 1'b0;
`endif

  assign w_cap_data = w_issue_ill ? 32'd0 : alu_out;
  assign w_cap_ovf  = alu_overflow & ~w_issue_ill;

  // Capture the ALU result at the end of ISSUE; hold it until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_out_overflow <= 1'b0;
      r_out_tag      <= '0;
    end else if (w_capture) begin
      r_out_valid    <= 1'b1;
      r_out_data     <= w_cap_data;
      r_out_overflow <= w_cap_ovf;
      r_out_tag      <= r_issue_tag;
    end else if (w_release) begin
      r_out_valid    <= 1'b0;
    end
  end

  assign alu_enable       = (r_state == S_ISSUE) & ~w_issue_ill;
  assign alu_op           = r_alu_op;
  assign src1             = r_src1;
  assign src2             = r_src2;
  assign fifo_count       = r_count;
  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_data     = r_out_data;
  assign bus.out_overflow = r_out_overflow;
  assign bus.out_tag      = r_out_tag;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: bench for alu_issue_ctrl with a behavioural ALU
// stand-in, a result queue reference model and randomized traffic.
module tb_alu_issue_ctrl;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Opcode encoding of the ALU stand-in (controller never decodes legal ops).
  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_ABS  = 5'd2;
  localparam logic [4:0] OP_ROTL = 5'd12;
  localparam logic [4:0] OP_ILL  = 5'b11111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();
  logic          alu_enable;
  logic [4:0]    alu_op;
  logic [31:0]   src1, src2, alu_out;
  logic          alu_overflow;
  logic [CW-1:0] fifo_count;

  alu_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .alu_enable(alu_enable), .alu_op(alu_op), .src1(src1), .src2(src2),
    .alu_out(alu_out), .alu_overflow(alu_overflow), .fifo_count(fifo_count)
  );

  function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] t;
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a[31] ? (32'd0 - a) : a;
      5'd3:  return a & b;
      5'd4:  return a | b;
      5'd5:  return a ^ b;
      5'd6:  return ~(a | b);
      5'd7:  return {31'd0, ($signed(a) < $signed(b))};
      5'd8:  return {31'd0, (a < b)};
      5'd9:  return a << b[4:0];
      5'd10: return a >> b[4:0];
      5'd11: return $signed(a) >>> b[4:0];
      5'd12: begin t = {a, a} << b[4:0]; return t[63:32]; end
      5'd13: begin t = {a, a} >> b[4:0]; return t[31:0]; end
      5'd14: return a * b;
      5'd15: return a;
      5'd16: return b;
      5'd17: return a >> b[4:0];
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  function automatic logic ovf_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      5'd0: begin r = a + b; return (a[31] == b[31]) && (r[31] != a[31]); end
      5'd1: begin r = a - b; return (a[31] != b[31]) && (r[31] != a[31]); end
      5'd2: return a == 32'h80000000;
      default: return 1'b0;
    endcase
  endfunction

  // combinational ALU stand-in
  always_comb begin
    alu_out      = alu_f(alu_op, src1, src2);
    alu_overflow = ovf_f(alu_op, src1, src2);
  end

  typedef struct {
    logic [31:0]      data;
    logic             ovf;
    logic [TAG_W-1:0] tag;
    logic             err;
    bit               chk_data;
  } res_t;

  res_t             exp_q[$];
  logic [TAG_W-1:0] seen_tags[$];
  int checks = 0;
  int failures = 0;
  int n_res = 0;
  int en_cnt = 0;
  logic prev_en = 1'b0;

  function automatic res_t predict(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [TAG_W-1:0] tag);
    res_t r;
    r.data = alu_f(op, a, b);
    r.ovf = ovf_f(op, a, b);
    r.tag = tag;
    r.err = 1'b0;
    r.chk_data = 1'b1;
    if (op > 5'd17) begin
`ifdef ALU_ILLEGAL_OP_CHK_EN
      r.data = 32'd0;
      r.ovf = 1'b0;
      r.err = 1'b1;
`else
      r.chk_data = 1'b0;
`endif
    end
    return r;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk32(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Per-cycle compare against the result queue and handshake properties.
  always @(negedge clk) begin : cmp
    res_t e;
    if (rst) begin
      exp_q.delete();
      prev_en = 1'b0;
    end else begin
      chk1("in_ready_vs_count", bus.in_ready, fifo_count != FULL);
      if (prev_en) begin
        chk1("valid_after_issue", bus.out_valid, 1'b1);
        chk1("enable_one_cycle", alu_enable, 1'b0);
      end
      prev_en = alu_enable;
      if (alu_enable) en_cnt++;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got tag %0d expected no result", bus.out_tag);
        end else begin
          e = exp_q[0];
          if (e.chk_data) begin
            chk32("out_data", bus.out_data, e.data);
            chk1("out_overflow", bus.out_overflow, e.ovf);
          end
          chk32("out_tag", 32'(bus.out_tag), 32'(e.tag));
          chk1("out_err", bus.out_err, e.err);
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            n_res++;
            seen_tags.push_back(bus.out_tag);
          end
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(predict(bus.in_op, bus.in_src1, bus.in_src2, bus.in_tag));
    end
  end

  // Called and returns at posedge+1; holds the command until accepted.
  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag);
    int w;
    bus.in_valid = 1'b1;
    bus.in_op = op;
    bus.in_src1 = a;
    bus.in_src2 = b;
    bus.in_tag = tag;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", w);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while ((exp_q.size() != 0 || bus.out_valid || fifo_count != '0) && w < 2000) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk1(name, w < 2000, 1'b1);
  endtask

  task automatic wait_valid(input string name);
    int w;
    w = 0;
    while (!bus.out_valid && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk1(name, bus.out_valid, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]      obs_d[4];
    logic             obs_o[4];
    int               obs_c[4];
    int               nobs;
    int               n0;
    int               w;
    int               nv;
    bit               done;
    logic [4:0]       rop;
    logic [31:0]      ra, rb;

    bus.in_valid = 1'b0;
    bus.in_op = '0;
    bus.in_src1 = '0;
    bus.in_src2 = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b0;
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // reset state
    chk1("rst_in_ready", bus.in_ready, 1'b1);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk32("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk1("rst_alu_enable", alu_enable, 1'b0);
    chk32("rst_out_data", bus.out_data, 32'd0);
    chk32("rst_alu_op", 32'(alu_op), 32'd0);
    chk1("rst_out_err", bus.out_err, 1'b0);

    // single ADD with signed overflow: latency and one-cycle enable
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_op = OP_ADD;
    bus.in_src1 = 32'h7FFFFFFF;
    bus.in_src2 = 32'h00000001;
    bus.in_tag = 4'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk32("t1_count_after_accept", 32'(fifo_count), 32'd1);
    chk1("t1_no_bypass_enable", alu_enable, 1'b0);
    @(posedge clk); #1;
    chk1("t1_issue_enable", alu_enable, 1'b1);
    chk32("t1_src1", src1, 32'h7FFFFFFF);
    chk32("t1_alu_op", 32'(alu_op), 32'(OP_ADD));
    chk1("t1_not_yet_valid", bus.out_valid, 1'b0);
    @(posedge clk); #1;
    chk1("t1_valid", bus.out_valid, 1'b1);
    chk32("t1_data", bus.out_data, 32'h80000000);
    chk1("t1_ovf", bus.out_overflow, 1'b1);
    chk32("t1_tag", 32'(bus.out_tag), 32'd3);
    chk1("t1_enable_low", alu_enable, 1'b0);
    @(posedge clk); #1;
    chk1("t1_valid_falls", bus.out_valid, 1'b0);

    // ROTL then SUB back-to-back: results in order, two cycles apart
    send(OP_ROTL, 32'h80000001, 32'd1, 4'd1);
    send(OP_SUB, 32'd5, 32'd7, 4'd2);
    nobs = 0;
    for (int c = 0; c < 4; c++) begin
      obs_d[c] = '0;
      obs_o[c] = 1'b1;
      obs_c[c] = 0;
    end
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid && nobs < 4) begin
        obs_d[nobs] = bus.out_data;
        obs_o[nobs] = bus.out_overflow;
        obs_c[nobs] = c;
        nobs++;
      end
    end
    chk32("t2_result_count", 32'(nobs), 32'd2);
    chk32("t2_rotl_data", obs_d[0], 32'h00000003);
    chk1("t2_rotl_ovf", obs_o[0], 1'b0);
    chk32("t2_sub_data", obs_d[1], 32'hFFFFFFFE);
    chk1("t2_sub_ovf", obs_o[1], 1'b0);
    chk32("t2_spacing", 32'(obs_c[1] - obs_c[0]), 32'd2);

    // back-pressure: six commands with out_ready low
    bus.out_ready = 1'b0;
    n0 = n_res;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(OP_ADD, 32'(i) * 32'h100, 32'h11, TAG_W'(i + 4));
      end
      begin
        repeat (12) @(posedge clk);
        #1;
        chk32("t3_full_count", 32'(fifo_count), 32'd4);
        chk1("t3_in_ready_low", bus.in_ready, 1'b0);
        chk1("t3_held_valid", bus.out_valid, 1'b1);
        chk32("t3_held_tag", 32'(bus.out_tag), 32'd4);
        chk32("t3_held_data_a", bus.out_data, 32'h11);
        repeat (3) @(posedge clk);
        #1;
        chk32("t3_held_data_b", bus.out_data, 32'h11);
        bus.out_ready = 1'b1;
      end
    join
    drain("t3_drain");
    chk32("t3_results", 32'(n_res - n0), 32'd6);

    // push and pop in the same cycle at count 2; tags 0..7 across wrap
    bus.out_ready = 1'b0;
    seen_tags.delete();
    send(OP_ADD, 32'd1, 32'd1, 4'd0);
    send(OP_ADD, 32'd2, 32'd2, 4'd1);
    send(OP_ADD, 32'd3, 32'd3, 4'd2);
    w = 0;
    while (!(fifo_count == CW'(2) && bus.out_valid) && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk32("t4_setup_count", 32'(fifo_count), 32'd2);
    bus.in_valid = 1'b1;
    bus.in_op = OP_ADD;
    bus.in_src1 = 32'd4;
    bus.in_src2 = 32'd4;
    bus.in_tag = 4'd3;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk32("t4_push_pop_count", 32'(fifo_count), 32'd2);
    for (int i = 4; i < 8; i++)
      send(OP_ADD, 32'(i), 32'(i), TAG_W'(i));
    drain("t4_drain");
    chk32("t4_seen_count", 32'(seen_tags.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < seen_tags.size())
        chk32("t4_tag_order", 32'(seen_tags[i]), 32'(i));

    // illegal opcode followed by a legal ADD
    en_cnt = 0;
    send(OP_ILL, 32'h1234, 32'h5678, 4'd9);
    wait_valid("t5_ill_valid");
    chk32("t5_ill_tag", 32'(bus.out_tag), 32'd9);
`ifdef ALU_ILLEGAL_OP_CHK_EN
    chk32("t5_ill_data", bus.out_data, 32'd0);
    chk1("t5_ill_err", bus.out_err, 1'b1);
    chk32("t5_ill_enable_cnt", 32'(en_cnt), 32'd0);
`else
    chk1("t5_ill_err", bus.out_err, 1'b0);
    chk32("t5_ill_enable_cnt", 32'(en_cnt), 32'd1);
`endif
    @(posedge clk); #1;
    en_cnt = 0;
    send(OP_ADD, 32'd2, 32'd3, 4'd10);
    wait_valid("t5_add_valid");
    chk32("t5_add_data", bus.out_data, 32'd5);
    chk1("t5_add_err", bus.out_err, 1'b0);
    chk32("t5_add_enable_cnt", 32'(en_cnt), 32'd1);
    @(posedge clk); #1;

    // asynchronous reset in the middle of ISSUE with three commands queued
    bus.out_ready = 1'b0;
    send(OP_ADD, 32'd10, 32'd20, 4'd1);
    for (int i = 0; i < 4; i++)
      send(OP_ADD, 32'(i), 32'd1, TAG_W'(i + 2));
    w = 0;
    while (!(fifo_count == FULL && bus.out_valid) && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk1("t6_in_issue", alu_enable, 1'b1);
    chk32("t6_queued", 32'(fifo_count), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk1("t6_rst_out_valid", bus.out_valid, 1'b0);
    chk1("t6_rst_alu_enable", alu_enable, 1'b0);
    chk32("t6_rst_count", 32'(fifo_count), 32'd0);
    chk1("t6_rst_in_ready", bus.in_ready, 1'b1);
    chk32("t6_rst_out_data", bus.out_data, 32'd0);
    chk32("t6_rst_src1", src1, 32'd0);
    #10 rst = 1'b0;
    @(posedge clk); #1;
    nv = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.out_valid) nv++;
      @(posedge clk); #1;
    end
    chk32("t6_no_stale", 32'(nv), 32'd0);
    send(OP_ADD, 32'd1, 32'd1, 4'd5);
    wait_valid("t6_new_valid");
    chk32("t6_new_data", bus.out_data, 32'd2);
    chk32("t6_new_tag", 32'(bus.out_tag), 32'd5);
    @(posedge clk); #1;

    // randomized traffic with random back-pressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          rop = 5'($urandom_range(0, 17));
`ifdef ALU_ILLEGAL_OP_CHK_EN
          if ($urandom_range(0, 7) == 0) rop = 5'($urandom_range(18, 31));
`endif
          case ($urandom_range(0, 3))
            0: ra = 32'h7FFFFFFF;
            1: ra = 32'h80000000;
            default: ra = $urandom;
          endcase
          rb = ($urandom_range(0, 3) == 0) ? 32'd1 : $urandom;
          send(rop, ra, rb, TAG_W'(i));
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain("t7_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
